// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the adder stimulus/checker
package adder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUT_RESET,
    ST_DRIVE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [15:0] LFSR_SEED      = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam int          DUT_RST_CYCLES = 2;

  // One Galois step: shift right, fold the taps in when a one falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/adder_lfsr.sv
// rtl/adder_lfsr.sv - 16-bit Galois LFSR producing {carry_in,b,a} vectors
module adder_lfsr
  import adder_pkg::*;
#(
  parameter int BIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 load,
  input  logic                 advance,
  output logic [2*BIT_WIDTH:0] vec
);

  logic [15:0] state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= LFSR_SEED;
    end else if (load) begin
      state <= LFSR_SEED;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

  // a and b sit side by side in the low bits, carry comes from the top bit.
  assign vec = {state[15], state[2*BIT_WIDTH-1:0]};

endmodule

// File: rtl/adder_stim_checker.sv
// rtl/adder_stim_checker.sv - drives vectors into an adder and scores its results
module adder_stim_checker
  import adder_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [15:0]          num_vectors,
  output logic                 dut_n_rst,
  output logic [BIT_WIDTH-1:0] a,
  output logic [BIT_WIDTH-1:0] b,
  output logic                 carry_in,
  input  logic [BIT_WIDTH-1:0] sum,
  input  logic                 overflow,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          error_count,
  output logic [15:0]          vector_count
);

  localparam int          VW          = 2 * BIT_WIDTH + 1;
  localparam logic [15:0] SWEEP_COUNT = 16'(1 << VW);
  localparam logic [1:0]  RST_LAST    = 2'(DUT_RST_CYCLES - 1);
  localparam logic [3:0]  DRAIN_LAST  = 4'(LATENCY - 1);

  state_t               state;
  logic                 mode_q;
  logic [15:0]          total_q;
  logic [1:0]           rst_cnt;
  logic [3:0]           drain_cnt;
  logic [VW-1:0]        lfsr_vec;
  logic [VW-1:0]        vec_next;
  logic                 start_ok;
  logic                 drive_vec;
  logic [BIT_WIDTH:0]   exp_now;
  logic                 mismatch;
  logic [15:0]          err_next;
  logic                 pipe_vld [LATENCY];
  logic [BIT_WIDTH:0]   pipe_exp [LATENCY];

  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
  assign drive_vec = (state == ST_DUT_RESET && rst_cnt == RST_LAST && total_q != 16'd0) ||
                     (state == ST_DRIVE && vector_count != total_q);
  assign vec_next  = mode_q ? lfsr_vec : vector_count[VW-1:0];

  adder_lfsr #(.BIT_WIDTH(BIT_WIDTH)) u_lfsr (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (start_ok),
    .advance (drive_vec && mode_q),
    .vec     (lfsr_vec)
  );

  // Expected result of whatever is on the operand bus this cycle.
  assign exp_now  = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};
  assign mismatch = pipe_vld[LATENCY-1] && ({overflow, sum} != pipe_exp[LATENCY-1]);
  assign err_next = (mismatch && error_count != 16'hFFFF) ? error_count + 16'd1 : error_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_exp[i] <= '0;
      end
    end else if (start_ok) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_exp[i] <= '0;
      end
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
      end
      pipe_vld[0] <= (state == ST_DRIVE);
      pipe_exp[0] <= exp_now;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      dut_n_rst    <= 1'b0;
      a            <= '0;
      b            <= '0;
      carry_in     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      error_count  <= 16'd0;
      vector_count <= 16'd0;
      mode_q       <= 1'b0;
      total_q      <= 16'd0;
      rst_cnt      <= 2'd0;
      drain_cnt    <= 4'd0;
    end else begin
      error_count <= err_next;
      case (state)
        ST_IDLE, ST_DONE: begin
          dut_n_rst <= 1'b1;
          if (start) begin
            state        <= ST_DUT_RESET;
            dut_n_rst    <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            error_count  <= 16'd0;
            vector_count <= 16'd0;
            mode_q       <= mode;
            total_q      <= mode ? num_vectors : SWEEP_COUNT;
            rst_cnt      <= 2'd0;
            {carry_in, b, a} <= '0;
          end
        end
        ST_DUT_RESET: begin
          if (rst_cnt == RST_LAST) begin
            dut_n_rst <= 1'b1;
            drain_cnt <= 4'd0;
            if (drive_vec) begin
              state            <= ST_DRIVE;
              {carry_in, b, a} <= vec_next;
              vector_count     <= vector_count + 16'd1;
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            rst_cnt <= rst_cnt + 2'd1;
          end
        end
        ST_DRIVE: begin
          if (drive_vec) begin
            {carry_in, b, a} <= vec_next;
            vector_count     <= vector_count + 16'd1;
          end else begin
            state            <= ST_DRAIN;
            {carry_in, b, a} <= '0;
            drain_cnt        <= 4'd0;
          end
        end
        ST_DRAIN: begin
          // The last vector's compare lands on the edge that enters DONE.
          if (drain_cnt == DRAIN_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 16'd0);
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
